// File: rtl/btn_cond2_pkg.sv
// Shared definitions for the two-channel button conditioner.
//   state_t       : per-channel debounce FSM state (2-bit, fixed encoding)
//   DB_CYCLES_DEF : default debounce window in clk cycles (10 ms @ 50 MHz)
//   CNT_W_DEF     : default debounce counter width
package btn_pkg;

    localparam int DB_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF     = 19;

    // The encoding is Gray-like around the cycle LO -> WAIT_HI -> HI -> WAIT_LO,
    // so bit 1 of the state already equals the accepted level in the
    // *_STABLE states.
    typedef enum logic [1:0] {
        LO_STABLE = 2'b00,
        WAIT_HI   = 2'b01,
        HI_STABLE = 2'b11,
        WAIT_LO   = 2'b10
    } state_t;

endpackage

// File: rtl/btn_cond2_if.sv
// Signal bundle between the raw board inputs and the sequence FSM.
//   a_raw, b_raw     : raw, asynchronous, bouncing inputs
//   a, b             : debounced levels
//   a_pulse, b_pulse : one-cycle pulses on accepted rising transitions
// master drives the raw inputs and observes the conditioned outputs;
// slave is the conditioner itself.
interface btn_cond2_if;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic a_pulse;
    logic b_pulse;

    modport master (output a_raw, b_raw, input  a, b, a_pulse, b_pulse);
    modport slave  (input  a_raw, b_raw, output a, b, a_pulse, b_pulse);
endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, counter-qualified FSM,
// registered level and registered rising-edge pulse.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   raw   : asynchronous, possibly bouncing input
//   level : debounced level
//   pulse : high for one cycle after each accepted 0->1 transition
module debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1, sync2;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             level_n, pulse_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= LO_STABLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            state <= state_n;
            cnt   <= cnt_n;
            level <= level_n;
            pulse <= pulse_n;
        end
    end

    // Counter only ever counts up to CNT_LAST, and any sample that disagrees
    // with the pending value drops straight back to the stable state, so a
    // new attempt always restarts from zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = level;
        pulse_n = 1'b0;
        case (state)
            LO_STABLE: begin
                if (sync2) begin
                    state_n = WAIT_HI;
                    cnt_n   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync2) begin
                    state_n = LO_STABLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = HI_STABLE;
                    level_n = 1'b1;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HI_STABLE: begin
                if (!sync2) begin
                    state_n = WAIT_LO;
                    cnt_n   = '0;
                end
            end
            WAIT_LO: begin
                if (sync2) begin
                    state_n = HI_STABLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = LO_STABLE;
                    level_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = LO_STABLE;
        endcase
    end

endmodule

// File: rtl/btn_cond2.sv
// Two-channel input conditioner feeding the a/b sequence FSM. Each raw input
// is synchronised, debounced over DB_CYCLES cycles and presented as a clean
// level plus a one-cycle rising-edge pulse. Channels are independent.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : btn_cond2_if.slave (a_raw/b_raw in; a, b, a_pulse, b_pulse out)
module btn_cond2
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    btn_cond2_if.slave  bus
);

    debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_a (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.a_raw),
        .level (bus.a),
        .pulse (bus.a_pulse)
    );

    debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_b (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.b_raw),
        .level (bus.b),
        .pulse (bus.b_pulse)
    );

endmodule

// File: tb/tb_btn_cond2.sv
// Self-checking bench for btn_cond2 (DB_CYCLES=4, CNT_W=3). Directed
// scenarios carry hand-derived cycle expectations; every cycle is also
// compared against a run-length reference model of the debouncer.
module tb_btn_cond2;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    btn_cond2_if bus ();

    btn_cond2 #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the debouncer sees the raw input two edges late; the
    // level flips once DB+1 consecutive observations disagree with it, and a
    // pulse accompanies every flip to 1.
    logic [1:0] m_d1, m_d2, m_lvl, m_pul;
    int         m_run [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pul = '0;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            logic [1:0] obs;
            obs   = m_d2;
            m_d2  = m_d1;
            m_d1  = {bus.b_raw, bus.a_raw};
            m_pul = '0;
            for (int c = 0; c < 2; c++) begin
                if (obs[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB + 1) begin
                        m_lvl[c] = obs[c];
                        m_pul[c] = obs[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.a_raw = 1'b0;
        bus.b_raw = 1'b0;
        rst = 1'b1;
        tick();
        tests++;
        if ({bus.a, bus.b, bus.a_pulse, bus.b_pulse} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hold got=%b exp=0000", {bus.a, bus.b, bus.a_pulse, bus.b_pulse});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({bus.a, bus.b, bus.a_pulse, bus.b_pulse} !== 4'b0000) begin
                fails++;
                $display("FAIL idle_low cyc=%0d got=%b exp=0000", i, {bus.a, bus.b, bus.a_pulse, bus.b_pulse});
            end
        end
    endtask

    task automatic test_press();
        logic [3:0] exp;
        bus.a_raw = 1'b1;              // before E0
        for (int i = 0; i <= 10; i++) begin
            tick();                    // after E_i
            exp = {(i >= 6), 1'b0, (i == 6), 1'b0};
            tests++;
            if ({bus.a, bus.b, bus.a_pulse, bus.b_pulse} !== exp) begin
                fails++;
                $display("FAIL press E%0d got=%b exp=%b", i, {bus.a, bus.b, bus.a_pulse, bus.b_pulse}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        pat = 5'b10101;                // applied MSB first: 1,0,1,0,1
        for (int i = 0; i <= 14; i++) begin
            bus.a_raw = (i < 5) ? pat[4-i] : 1'b0;
            tick();
            tests++;
            // last 1->0 lands before E5, so the level falls after E11
            if ({bus.a, bus.a_pulse} !== {(i < 11), 1'b0}) begin
                fails++;
                $display("FAIL bounce E%0d got=%b exp=%b", i, {bus.a, bus.a_pulse}, {(i < 11), 1'b0});
            end
        end
    endtask

    task automatic test_short();
        for (int i = 0; i < 14; i++) begin
            bus.a_raw = (i < 3);
            tick();
            tests++;
            if ({bus.a, bus.a_pulse} !== 2'b00) begin
                fails++;
                $display("FAIL short E%0d got=%b exp=00", i, {bus.a, bus.a_pulse});
            end
        end
    endtask

    task automatic test_both();
        logic [3:0] exp;
        bus.a_raw = 1'b1;
        bus.b_raw = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            tick();
            exp = {(i >= 6), (i >= 6), (i == 6), (i == 6)};
            tests++;
            if ({bus.a, bus.b, bus.a_pulse, bus.b_pulse} !== exp) begin
                fails++;
                $display("FAIL both E%0d got=%b exp=%b", i, {bus.a, bus.b, bus.a_pulse, bus.b_pulse}, exp);
            end
        end
        bus.a_raw = 1'b0;
        bus.b_raw = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        tests++;
        if ({bus.a, bus.b, bus.a_pulse, bus.b_pulse} !== 4'b0000) begin
            fails++;
            $display("FAIL both_release got=%b exp=0000", {bus.a, bus.b, bus.a_pulse, bus.b_pulse});
        end
    endtask

    task automatic test_reset_mid();
        bus.a_raw = 1'b1;              // before E0
        for (int i = 0; i <= 4; i++) tick();   // after E4: WAIT_HI, cnt=2
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.a, bus.a_pulse} !== 2'b00) begin
            fails++;
            $display("FAIL rst_mid_now got=%b exp=00", {bus.a, bus.a_pulse});
        end
        tick();
        rst = 1'b0;
        for (int j = 0; j <= 9; j++) begin
            tick();                    // after first post-reset edge F_j
            tests++;
            if ({bus.a, bus.a_pulse} !== {(j >= 6), (j == 6)}) begin
                fails++;
                $display("FAIL rst_mid F%0d got=%b exp=%b", j, {bus.a, bus.a_pulse}, {(j >= 6), (j == 6)});
            end
        end
        // Pulse due on the reset edge must vanish: assert reset across E6.
        bus.a_raw = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        bus.a_raw = 1'b1;
        for (int i = 0; i <= 5; i++) tick();
        rst = 1'b1;
        tick();                        // E6 happens under reset
        tests++;
        if ({bus.a, bus.a_pulse} !== 2'b00) begin
            fails++;
            $display("FAIL rst_suppress got=%b exp=00", {bus.a, bus.a_pulse});
        end
        rst = 1'b0;
        bus.a_raw = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_random();
        int hold [2];
        int rhold;
        hold[0] = 0; hold[1] = 0; rhold = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    if (c == 0) bus.a_raw = ~bus.a_raw;
                    else        bus.b_raw = ~bus.b_raw;
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14)
                                                          : $urandom_range(1, 6);
                end
                hold[c]--;
            end
            if (rhold > 0) rhold--;
            else if ($urandom_range(0, 299) == 0) rhold = 1;
            rst = (rhold > 0);
            tick();
            tests++;
            if ({bus.b, bus.a, bus.b_pulse, bus.a_pulse} !== {m_lvl, m_pul}) begin
                fails++;
                $display("FAIL random cyc=%0d got(b,a,bp,ap)=%b exp=%b", i,
                         {bus.b, bus.a, bus.b_pulse, bus.a_pulse}, {m_lvl, m_pul});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.a_raw = 1'b0;
        bus.b_raw = 1'b0;
        @(negedge clk);
        test_reset();
        test_press();
        test_bounce();
        test_short();
        test_both();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
